// File: rtl/pm_fetch_unit.sv
// pm_fetch_unit: program-memory fetch with redirects, return stack and stall handling
module pm_fetch_unit #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32,
  parameter int STK_DEPTH = 8,
  parameter logic [PMA_SIZE-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         jmp_en,
  input  logic                         call_en,
  input  logic                         rts_en,
  input  logic [PMA_SIZE-1:0]          tgt_add,
  input  logic [PMD_SIZE-1:0]          pm_ps_op,
  output logic                         ps_pm_cslt,
  output logic                         ps_pm_wrb,
  output logic [PMA_SIZE-1:0]          ps_pm_add,
  output logic [PMD_SIZE-1:0]          inst,
  output logic [PMA_SIZE-1:0]          inst_pc,
  output logic                         inst_vld,
  output logic [$clog2(STK_DEPTH):0]   stk_lvl,
  output logic                         stk_ovf,
  output logic                         stk_unf
);
  localparam int SW = $clog2(STK_DEPTH);
  logic [PMA_SIZE-1:0] fa_q, fa_d, inst_pc_q;
  logic run_q, inst_vld_q, ovf_q, unf_q;
  logic [SW:0] lvl_q, lvl_d;
  logic [SW-1:0] top_idx;
  logic [PMA_SIZE-1:0] stk_q [STK_DEPTH];
  logic adv, rts_ok, rts_bad, call_ok, push, jmp_ok, redir;
  // Redirect decode and next fetch address; requests only count on a valid instruction
  always_comb begin
    adv     = run_q & ~stall;
    rts_ok  = inst_vld_q & rts_en & (lvl_q != '0);
    rts_bad = inst_vld_q & rts_en & (lvl_q == '0);
    call_ok = inst_vld_q & ~rts_en & call_en;
    push    = call_ok & (lvl_q != (SW+1)'(STK_DEPTH));
    jmp_ok  = inst_vld_q & ~rts_en & ~call_en & jmp_en;
    redir   = rts_ok | call_ok | jmp_ok;
    top_idx = SW'(lvl_q - 1'b1);
    fa_d    = rts_ok ? stk_q[top_idx] : (call_ok | jmp_ok) ? tgt_add : fa_q + 1'b1;
    lvl_d   = rts_ok ? lvl_q - 1'b1 : push ? lvl_q + 1'b1 : lvl_q;
  end
  // Fetch pipeline state; everything freezes while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fa_q       <= RESET_PC;
      run_q      <= 1'b0;
      inst_pc_q  <= '0;
      inst_vld_q <= 1'b0;
      lvl_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (adv) begin
        inst_pc_q  <= fa_q;
        inst_vld_q <= ~redir;
        fa_q       <= fa_d;
        lvl_q      <= lvl_d;
        ovf_q      <= ovf_q | (call_ok & ~push);
        unf_q      <= unf_q | rts_bad;
      end
    end
  end
  // Return-address storage is not reset; run_q is low during reset so no push can land
  always_ff @(posedge clk) begin
    if (adv && push) stk_q[lvl_q[SW-1:0]] <= inst_pc_q + 1'b1;
  end
  assign ps_pm_cslt = run_q & ~stall;
  assign ps_pm_wrb  = 1'b0;
  assign ps_pm_add  = fa_q;
  assign inst       = pm_ps_op;
  assign inst_pc    = inst_pc_q;
  assign inst_vld   = inst_vld_q;
  assign stk_lvl    = lvl_q;
  assign stk_ovf    = ovf_q;
  assign stk_unf    = unf_q;
endmodule

// File: tb/tb_pm_fetch_unit.sv
// tb_pm_fetch_unit: directed and random checks of the fetch unit against a PC/stack reference model
module tb_pm_fetch_unit;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, jmp_en = 1'b0, call_en = 1'b0, rts_en = 1'b0;
  logic [15:0] tgt_add = '0;
  logic [31:0] pm_ps_op = '0;
  logic ps_pm_cslt, ps_pm_wrb, inst_vld, stk_ovf, stk_unf;
  logic [15:0] ps_pm_add, inst_pc;
  logic [31:0] inst;
  logic [3:0] stk_lvl;
  int tests = 0, fails = 0;
  logic [15:0] m_fa = '0, m_pc = '0;
  bit m_vld = 0, m_run = 0, m_ovf = 0, m_unf = 0;
  logic [15:0] m_stk [$];

  pm_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .jmp_en(jmp_en), .call_en(call_en),
    .rts_en(rts_en), .tgt_add(tgt_add), .pm_ps_op(pm_ps_op), .ps_pm_cslt(ps_pm_cslt),
    .ps_pm_wrb(ps_pm_wrb), .ps_pm_add(ps_pm_add), .inst(inst), .inst_pc(inst_pc),
    .inst_vld(inst_vld), .stk_lvl(stk_lvl), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Program memory: registers the addressed word on a selected edge
  always @(posedge clk) if (ps_pm_cslt) pm_ps_op <= word(ps_pm_add);

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("add", 64'(ps_pm_add), 64'(m_fa));
    chk("cslt", 64'(ps_pm_cslt), 64'(m_run & ~stall));
    chk("wrb", 64'(ps_pm_wrb), 64'(0));
    chk("pc", 64'(inst_pc), 64'(m_pc));
    chk("vld", 64'(inst_vld), 64'(m_vld));
    chk("lvl", 64'(stk_lvl), 64'(m_stk.size()));
    chk("ovf", 64'(stk_ovf), 64'(m_ovf));
    chk("unf", 64'(stk_unf), 64'(m_unf));
    if (m_vld) chk("inst", 64'(inst), 64'(word(m_pc)));
  endtask

  task automatic mreset();
    m_fa = '0; m_pc = '0; m_vld = 0; m_run = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // One clock: apply inputs, advance the reference model at the edge, check just after
  task automatic cycle(bit st, bit j, bit c, bit r, logic [15:0] t);
    logic [15:0] nxt;
    bit red;
    stall = st; jmp_en = j; call_en = c; rts_en = r; tgt_add = t;
    @(posedge clk);
    if (m_run && !st) begin
      nxt = m_fa + 16'd1;
      red = 0;
      if (m_vld) begin
        if (r) begin
          if (m_stk.size() > 0) begin nxt = m_stk.pop_back(); red = 1; end
          else m_unf = 1;
        end else if (c) begin
          if (m_stk.size() < 8) m_stk.push_back(m_pc + 16'd1);
          else m_ovf = 1;
          nxt = t; red = 1;
        end else if (j) begin
          nxt = t; red = 1;
        end
      end
      m_pc = m_fa; m_vld = !red; m_fa = nxt;
    end
    m_run = 1;
    #1;
    check_all();
  endtask

  task automatic run_to(logic [15:0] pc);
    for (int n = 0; n < 300 && !(m_vld && m_pc == pc); n++) cycle(0, 0, 0, 0, '0);
    chk("reach_pc", 64'(inst_pc), 64'(pc));
  endtask

  initial begin
    mreset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    // free-run from reset
    cycle(0, 0, 0, 0, '0);
    chk("run_add0", 64'(ps_pm_add), 64'(0));
    cycle(0, 0, 0, 0, '0);
    chk("first_vld", 64'(inst_vld), 64'(1));
    chk("first_inst", 64'(inst), 64'(word(16'h0)));
    run_to(16'h5);
    // stall three cycles
    repeat (3) begin
      cycle(1, 0, 0, 0, '0);
      chk("stall_pc", 64'(inst_pc), 64'(5));
    end
    cycle(1, 1, 1, 1, 16'h0BAD);
    cycle(0, 0, 0, 0, '0);
    chk("resume_pc", 64'(inst_pc), 64'(6));
    // jump with one bubble
    run_to(16'h10);
    cycle(0, 1, 0, 0, 16'h0100);
    chk("jmp_bubble", 64'(inst_vld), 64'(0));
    cycle(0, 1, 0, 0, 16'h0777);
    chk("jmp_tgt", 64'(inst_pc), 64'(16'h0100));
    cycle(0, 0, 0, 0, '0);
    // call / return
    cycle(0, 1, 0, 0, 16'h001C);
    run_to(16'h20);
    cycle(0, 0, 1, 0, 16'h0200);
    chk("call_lvl", 64'(stk_lvl), 64'(1));
    run_to(16'h0203);
    cycle(0, 0, 0, 1, '0);
    chk("rts_lvl", 64'(stk_lvl), 64'(0));
    cycle(0, 0, 0, 0, '0);
    chk("rts_pc", 64'(inst_pc), 64'(16'h21));
    // address wrap
    cycle(0, 1, 0, 0, 16'hFFFC);
    cycle(0, 0, 0, 0, '0);
    run_to(16'h0001);
    // nested calls past the stack depth, then returns past empty
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 1, 0, 16'h1000 + 16'(i * 256));
      cycle(0, 0, 0, 0, '0);
    end
    chk("ovf9", 64'(stk_ovf), 64'(1));
    chk("lvl9", 64'(stk_lvl), 64'(8));
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 1, '0);
      cycle(0, 0, 0, 0, '0);
    end
    chk("unf9", 64'(stk_unf), 64'(1));
    chk("lvl0", 64'(stk_lvl), 64'(0));
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      cycle(($urandom_range(0, 3) == 0), k == 0, k == 1 || k == 2, k == 3 || k == 4,
            16'($urandom()));
    end
    // asynchronous reset in the middle of a jump
    run_to(m_pc + 16'd2);
    jmp_en = 1'b1; tgt_add = 16'h3000;
    #3 reset = 1'b0;
    #1;
    mreset();
    check_all();
    jmp_en = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    chk("restart_pc", 64'(inst_pc), 64'(0));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
